// File: rtl/quad_encoder_emulator.sv
// quad_encoder_emulator
// Synthetic quadrature encoder. A signed speed command (edges per window) is
// turned into A/B Gray-coded phase signals. The edges are spread evenly across
// each window by an error accumulator, and a signed position tally follows
// every emitted edge.
module quad_encoder_emulator #(
    parameter int WINDOW_CYCLES = 100_000,
    parameter int SPEED_W       = 16,
    parameter int MAX_EDGES     = 25_000,
    parameter int POS_W         = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic signed [SPEED_W-1:0] speed_in,
    input  logic                      speed_load,
    output logic                      A,
    output logic                      B,
    output logic signed [POS_W-1:0]   position,
    output logic                      window_tick,
    output logic                      sat
);

    localparam int WCNT_W = $clog2(WINDOW_CYCLES);
    localparam int ACC_W  = $clog2(WINDOW_CYCLES) + 1;
    localparam int MAG_W  = SPEED_W + 1;

    localparam logic [WCNT_W-1:0] WCNT_LAST  = WCNT_W'(WINDOW_CYCLES - 1);
    localparam logic [ACC_W-1:0]  ACC_WINDOW = ACC_W'(WINDOW_CYCLES);
    localparam logic [MAG_W-1:0]  MAG_MAX    = MAG_W'(MAX_EDGES);

    // Encoding equals {A,B}, so the pins come straight off the state register.
    typedef enum logic [1:0] {
        PH_00 = 2'b00,
        PH_10 = 2'b10,
        PH_11 = 2'b11,
        PH_01 = 2'b01
    } phase_t;

    logic [WCNT_W-1:0]         wcnt_reg;
    logic signed [SPEED_W-1:0] pending_reg;
    logic signed [SPEED_W-1:0] active_reg;
    logic                      sat_reg;
    logic [ACC_W-1:0]          acc_reg;
    phase_t                    phase_reg;
    logic signed [POS_W-1:0]   position_reg;

    logic                      boundary;
    logic signed [SPEED_W-1:0] cmd_next;
    logic [MAG_W-1:0]          active_abs;
    logic [MAG_W-1:0]          mag;
    logic [ACC_W-1:0]          mag_acc;
    logic [ACC_W-1:0]          acc_sum;
    logic [ACC_W-1:0]          acc_next;
    logic                      step;
    logic                      dir_rev;

    // Magnitude in one extra bit so that the most negative command stays exact.
    function automatic logic [MAG_W-1:0] abs_ext(input logic signed [SPEED_W-1:0] v);
        logic [MAG_W-1:0] x;
        x = {v[SPEED_W-1], v};
        return v[SPEED_W-1] ? (~x + MAG_W'(1)) : x;
    endfunction

    assign boundary    = (wcnt_reg == WCNT_LAST);
    assign window_tick = boundary;

    // A load coinciding with the boundary bypasses pending and lands in active.
    assign cmd_next   = speed_load ? speed_in : pending_reg;
    assign active_abs = abs_ext(active_reg);
    assign mag        = (active_abs > MAG_MAX) ? MAG_MAX : active_abs;
    assign mag_acc    = ACC_W'(mag);
    assign dir_rev    = active_reg[SPEED_W-1];

    // Window counter: free-running 0..WINDOW_CYCLES-1, independent of en.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt_reg <= '0;
        end else if (boundary) begin
            wcnt_reg <= '0;
        end else begin
            wcnt_reg <= wcnt_reg + WCNT_W'(1);
        end
    end

    // Command path: pending follows every load, active/sat change only at the boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_reg <= '0;
            active_reg  <= '0;
            sat_reg     <= 1'b0;
        end else begin
            if (speed_load) begin
                pending_reg <= speed_in;
            end
            if (boundary) begin
                active_reg <= cmd_next;
                sat_reg    <= (abs_ext(cmd_next) > MAG_MAX);
            end
        end
    end

    // Accumulator step decision. The last cycle of the window also accumulates:
    // a full window adds exactly mag*WINDOW_CYCLES, so the final step lands on
    // the boundary cycle and the residue there is zero. Clearing at the boundary
    // only discards leftovers from windows cut short by en.
    always_comb begin
        acc_sum  = acc_reg + mag_acc;
        step     = 1'b0;
        acc_next = acc_sum;
        if (en && (acc_sum >= ACC_WINDOW)) begin
            step     = 1'b1;
            acc_next = acc_sum - ACC_WINDOW;
        end
        if (boundary || !en) begin
            acc_next = '0;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_reg <= '0;
        end else begin
            acc_reg <= acc_next;
        end
    end

    // Phase FSM and position tally: advance one Gray step per accumulator step.
    // Direction is read from the current window, so a reversal simply walks
    // back from whatever state the pins are in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_reg    <= PH_00;
            position_reg <= '0;
        end else if (step) begin
            if (dir_rev) begin
                case (phase_reg)
                    PH_00:   phase_reg <= PH_01;
                    PH_01:   phase_reg <= PH_11;
                    PH_11:   phase_reg <= PH_10;
                    default: phase_reg <= PH_00;
                endcase
                position_reg <= position_reg - POS_W'(1);
            end else begin
                case (phase_reg)
                    PH_00:   phase_reg <= PH_10;
                    PH_10:   phase_reg <= PH_11;
                    PH_11:   phase_reg <= PH_01;
                    default: phase_reg <= PH_00;
                endcase
                position_reg <= position_reg + POS_W'(1);
            end
        end
    end

    assign A        = phase_reg[1];
    assign B        = phase_reg[0];
    assign position = position_reg;
    assign sat      = sat_reg;

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// tb_quad_encoder_emulator
// Scoreboard bench: each speed command pushes per-window expectations
// (edge count, direction, saturation, end phase, edge spacing); a pin monitor
// decodes A/B and pops/compares one entry per completed window.
module tb_quad_encoder_emulator;

    localparam int W    = 100;
    localparam int MAXE = 25;
    localparam int SW   = 16;
    localparam int PW   = 32;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 en;
    logic signed [SW-1:0] speed_in;
    logic                 speed_load;
    logic                 A;
    logic                 B;
    logic signed [PW-1:0] position;
    logic                 window_tick;
    logic                 sat;

    always #5 clk = ~clk;

    quad_encoder_emulator #(
        .WINDOW_CYCLES(W),
        .SPEED_W(SW),
        .MAX_EDGES(MAXE),
        .POS_W(PW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .speed_in(speed_in),
        .speed_load(speed_load),
        .A(A),
        .B(B),
        .position(position),
        .window_tick(window_tick),
        .sat(sat)
    );

    typedef struct {
        int         win;
        int         delta;
        int         fwd;
        int         rev;
        bit         sat;
        int         gmin;
        int         gmax;
        logic [1:0] ab;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         cur_win = 0;
    int         last_pushed = -1;
    int         model_speed = 0;
    logic [1:0] ab_model = 2'b00;
    int         dec_count = 0;
    int         edge_total = 0;

    function automatic logic [1:0] gray_fwd(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] gray_rev(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] gray_advance(input logic [1:0] s, input int n);
        logic [1:0] r;
        r = s;
        if (n >= 0) begin
            for (int i = 0; i < n; i++) r = gray_fwd(r);
        end else begin
            for (int i = 0; i < -n; i++) r = gray_rev(r);
        end
        return r;
    endfunction

    // Expected behaviour of one full window at a given command.
    task automatic push_window(input int w, input int spd);
        exp_t e;
        int   m;
        m = (spd < 0) ? -spd : spd;
        e.sat   = (m > MAXE);
        if (m > MAXE) m = MAXE;
        e.win   = w;
        e.delta = (spd < 0) ? -m : m;
        e.fwd   = (spd < 0) ? 0 : m;
        e.rev   = (spd < 0) ? m : 0;
        e.gmin  = (m > 0) ? (W / m) : 0;
        e.gmax  = (m > 0) ? ((W + m - 1) / m) : 0;
        ab_model = gray_advance(ab_model, e.delta);
        e.ab    = ab_model;
        sb.push_back(e);
        last_pushed = w;
    endtask

    // Pin monitor: decodes A/B, checks Gray steps and window period, and closes
    // each window one cycle after its tick (when the boundary step is visible).
    task automatic monitor_loop();
        int         cyc = 0;
        int         last_edge = -1;
        int         last_tick = -1;
        int         gmin_obs = 1000000;
        int         gmax_obs = 0;
        int         wfwd = 0;
        int         wrev = 0;
        int         gap;
        int         pos_start = 0;
        int         delta;
        int         w;
        bit         fin_pend = 0;
        bit         sat_tick = 0;
        logic [1:0] ab_prev = 2'b00;
        logic [1:0] ab_now;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (reset) begin
                cyc = 0; last_edge = -1; last_tick = -1;
                gmin_obs = 1000000; gmax_obs = 0; wfwd = 0; wrev = 0;
                pos_start = 0; fin_pend = 0; ab_prev = 2'b00; cur_win = 0;
            end else begin
                cyc++;
                ab_now = {A, B};
                if (ab_now !== ab_prev) begin
                    n_cmp++;
                    if (ab_now === gray_fwd(ab_prev)) begin
                        wfwd++; dec_count++;
                    end else if (ab_now === gray_rev(ab_prev)) begin
                        wrev++; dec_count--;
                    end else begin
                        n_err++;
                        $display("FAIL gray_step: AB went %b -> %b, required a single-bit step", ab_prev, ab_now);
                    end
                    edge_total++;
                    if (last_edge >= 0) begin
                        gap = cyc - last_edge;
                        if (gap < gmin_obs) gmin_obs = gap;
                        if (gap > gmax_obs) gmax_obs = gap;
                    end
                    last_edge = cyc;
                    ab_prev = ab_now;
                end
                if (fin_pend) begin
                    fin_pend  = 0;
                    w         = cur_win - 1;
                    delta     = int'(position) - pos_start;
                    pos_start = int'(position);
                    if (sb.size() > 0 && sb[0].win < w) begin
                        n_cmp++; n_err++;
                        $display("FAIL sb_order: entry for window %0d unchecked at window %0d", sb[0].win, w);
                        void'(sb.pop_front());
                    end
                    if (sb.size() > 0 && sb[0].win == w) begin
                        e = sb.pop_front();
                        n_cmp++;
                        if (delta !== e.delta) begin
                            n_err++; $display("FAIL win%0d_position_delta: got %0d required %0d", w, delta, e.delta);
                        end
                        n_cmp++;
                        if (wfwd !== e.fwd || wrev !== e.rev) begin
                            n_err++; $display("FAIL win%0d_edges: got fwd %0d rev %0d required fwd %0d rev %0d", w, wfwd, wrev, e.fwd, e.rev);
                        end
                        n_cmp++;
                        if (sat_tick !== e.sat) begin
                            n_err++; $display("FAIL win%0d_sat: got %0d required %0d", w, sat_tick, e.sat);
                        end
                        n_cmp++;
                        if (ab_now !== e.ab) begin
                            n_err++; $display("FAIL win%0d_end_phase: got %b required %b", w, ab_now, e.ab);
                        end
                        if (e.gmin > 0 && (wfwd + wrev) >= 2) begin
                            n_cmp++;
                            if (gmin_obs < e.gmin || gmax_obs > e.gmax) begin
                                n_err++; $display("FAIL win%0d_spacing: got %0d..%0d required %0d..%0d", w, gmin_obs, gmax_obs, e.gmin, e.gmax);
                            end
                        end
                        $display("window %0d: delta %0d fwd %0d rev %0d sat %0d AB %b gaps %0d..%0d", w, delta, wfwd, wrev, sat_tick, ab_now, gmin_obs, gmax_obs);
                    end
                    wfwd = 0; wrev = 0; gmin_obs = 1000000; gmax_obs = 0; last_edge = -1;
                end
                if (window_tick === 1'b1) begin
                    if (last_tick >= 0) begin
                        n_cmp++;
                        if ((cyc - last_tick) !== W) begin
                            n_err++; $display("FAIL tick_period: got %0d required %0d", cyc - last_tick, W);
                        end
                    end
                    last_tick = cyc;
                    sat_tick  = sat;
                    cur_win++;
                    fin_pend  = 1;
                end
            end
        end
    endtask

    // Load a command d cycles into a window and expect it from the next window on.
    task automatic run_speed(input int spd, input int nwin, input int d);
        int guard;
        int t;
        int first;
        first = (last_pushed + 1 > cur_win) ? last_pushed + 1 : cur_win;
        for (int w = first; w <= cur_win; w++) push_window(w, model_speed);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (window_tick !== 1'b1 && guard < 3 * W);
        n_cmp++;
        if (window_tick !== 1'b1) begin
            n_err++; $display("FAIL sync_tick: no window_tick within %0d cycles", 3 * W);
        end
        repeat (d + 1) @(posedge clk);
        #1;
        speed_in   = SW'(spd);
        speed_load = 1'b1;
        t = cur_win + 1;
        @(posedge clk);
        #1 speed_load = 1'b0;
        first = (last_pushed + 1 > cur_win) ? last_pushed + 1 : cur_win;
        for (int w = first; w < t; w++) push_window(w, model_speed);
        for (int w = t; w < t + nwin; w++) push_window(w, spd);
        model_speed = spd;
        $display("load %0d at wcnt %0d, applies from window %0d", spd, d, t);
        guard = 0;
        while (sb.size() > 0 && guard < (nwin + 3) * W) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (sb.size() !== 0) begin
            n_err++; $display("FAIL sb_drain: %0d windows still expected, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1; en = 1'b1; speed_in = '0; speed_load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({A, B, window_tick, sat} !== 4'b0000 || position !== 0) begin
            n_err++; $display("FAIL reset_init: AB %b tick %b sat %b pos %0d required all 0", {A, B}, window_tick, sat, position);
        end
        reset = 1'b0;
        @(posedge clk);
        #1 speed_in = 16'sd10; speed_load = 1'b1;
        @(posedge clk);
        #1 speed_load = 1'b0;
        repeat (150) @(posedge clk);
        n_cmp++;
        if (position == 0) begin
            n_err++; $display("FAIL pre_reset_running: position %0d, required nonzero", position);
        end
        #3 reset = 1'b1;
        #1;
        n_cmp++;
        if ({A, B} !== 2'b00) begin
            n_err++; $display("FAIL reset_ab: got %b required 00", {A, B});
        end
        n_cmp++;
        if (position !== 0) begin
            n_err++; $display("FAIL reset_position: got %0d required 0", position);
        end
        n_cmp++;
        if (window_tick !== 1'b0 || sat !== 1'b0) begin
            n_err++; $display("FAIL reset_tick_sat: got %b%b required 00", window_tick, sat);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (window_tick !== 1'b1 && n < 3 * W);
        n_cmp++;
        if (n !== W) begin
            n_err++; $display("FAIL first_tick: tick in cycle %0d after release, required %0d", n, W);
        end
        $display("reset: first window_tick in cycle %0d after release", n);
        sb.delete();
        last_pushed = -1; model_speed = 0; ab_model = 2'b00;
    endtask

    task automatic test_forward();
        run_speed(4, 2, 10);
    endtask

    task automatic test_reverse();
        run_speed(-3, 2, 10);
    endtask

    task automatic test_saturation();
        run_speed(200, 2, 10);
        run_speed(-32768, 2, 10);
    endtask

    task automatic test_midwindow_load();
        run_speed(4, 1, 10);
        run_speed(8, 2, 40);
    endtask

    task automatic test_tick_load();
        run_speed(5, 1, 99);
    endtask

    task automatic test_zero();
        run_speed(0, 1, 10);
    endtask

    task automatic test_loopback();
        int         p0;
        int         d0;
        int         p1;
        int         e0;
        logic [1:0] ab0;
        p0 = int'(position);
        d0 = dec_count;
        @(posedge clk);
        #1 speed_in = 16'sd7; speed_load = 1'b1;
        @(posedge clk);
        #1 speed_load = 1'b0;
        repeat (250) @(posedge clk);
        #1 en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ab0 = {A, B}; p1 = int'(position); e0 = edge_total;
        repeat (150) @(negedge clk);
        n_cmp++;
        if (edge_total !== e0) begin
            n_err++; $display("FAIL en0_edges: got %0d edges required 0", edge_total - e0);
        end
        n_cmp++;
        if (int'(position) !== p1 || {A, B} !== ab0) begin
            n_err++; $display("FAIL en0_hold: pos %0d AB %b required pos %0d AB %b", position, {A, B}, p1, ab0);
        end
        @(posedge clk);
        #1 en = 1'b1;
        repeat (300) @(posedge clk);
        #1 en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ((dec_count - d0) !== (int'(position) - p0)) begin
            n_err++; $display("FAIL loopback_delta: counter %0d position %0d, required equal", dec_count - d0, int'(position) - p0);
        end
        n_cmp++;
        if ((dec_count - d0) <= 0) begin
            n_err++; $display("FAIL loopback_moved: counter delta %0d, required > 0", dec_count - d0);
        end
        $display("loopback: counter delta %0d position delta %0d", dec_count - d0, int'(position) - p0);
        en = 1'b1;
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; speed_in = '0; speed_load = 1'b0;
        fork
            monitor_loop();
            begin
                test_reset();
                test_forward();
                test_reverse();
                test_saturation();
                test_midwindow_load();
                test_tick_load();
                test_zero();
                test_loopback();
                n_cmp++;
                if (sb.size() !== 0) begin
                    n_err++; $display("FAIL sb_leftover: %0d entries, required 0", sb.size());
                end
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
                $finish;
            end
        join_any
    end

endmodule
